// File: rtl/mbus_tx_sched.sv
// Round-robin scheduler sharing one MBus node TX port between NUM_REQ requesters.
// Handles multi-word sequencing, single-word retry and a per-message watchdog.
module mbus_tx_sched #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic                             CLK_EXT,
    input  logic                             RESETn,
    input  logic [NUM_REQ-1:0]               REQ_VALID,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_DATA,
    input  logic [NUM_REQ-1:0]               REQ_PEND,
    output logic [NUM_REQ-1:0]               REQ_READY,
    output logic [NUM_REQ-1:0]               REQ_DONE,
    output logic [NUM_REQ-1:0]               REQ_FAIL,
    output logic [NUM_REQ-1:0]               GRANT,
    output logic [ADDR_WIDTH-1:0]            TX_ADDR,
    output logic [DATA_WIDTH-1:0]            TX_DATA,
    output logic                             TX_REQ,
    output logic                             TX_PEND,
    input  logic                             TX_ACK,
    input  logic                             TX_SUCC,
    input  logic                             TX_FAIL,
    output logic                             TX_RESP_ACK,
    input  logic [TIMEOUT_WIDTH-1:0]         TIMEOUT,
    output logic                             BUSY
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        StIdle, StArb, StSend, StAckLow, StNext, StResult, StResp
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         gidx_q, gidx_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     pend_q, pend_d;
    logic                     multi_q, multi_d;
    logic                     retrying_q, retrying_d;
    logic [2:0]               retry_q, retry_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;

    logic [ADDR_WIDTH-1:0]    req_addr [NUM_REQ];
    logic [DATA_WIDTH-1:0]    req_data [NUM_REQ];
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_found;
    logic [IDX_W-1:0]         next_rr;
    logic                     counted;
    logic                     wd_fire;
    logic                     timeout;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_addr[gi] = REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_data[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or above the RR pointer, with wrap
    always_comb begin
        int unsigned      j;
        logic [IDX_W-1:0] jj;
        arb_found = 1'b0;
        arb_idx   = '0;
        j         = 0;
        jj        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j  = (32'(rr_q) + k) % NUM_REQ;
            jj = IDX_W'(j);
            if (!arb_found && REQ_VALID[jj]) begin
                arb_found = 1'b1;
                arb_idx   = jj;
            end
        end
    end

    assign next_rr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
    assign counted = (state_q == StSend) || (state_q == StAckLow) ||
                     (state_q == StNext) || (state_q == StResult);
    assign wd_fire = (TIMEOUT != '0) && (wd_q == TIMEOUT - TIMEOUT_WIDTH'(1));
    // A node response already on the wire beats the watchdog, so RESP still handshakes
    assign timeout = counted && wd_fire && !((state_q == StResult) && (TX_SUCC || TX_FAIL));

    always_comb begin
        state_d    = state_q;
        gidx_d     = gidx_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        pend_d     = pend_q;
        multi_d    = multi_q;
        retrying_d = retrying_q;
        retry_d    = retry_q;
        wd_d       = wd_q;
        GRANT      = '0;
        REQ_READY  = '0;
        REQ_DONE   = '0;
        REQ_FAIL   = '0;

        if (counted) begin
            wd_d = wd_q + TIMEOUT_WIDTH'(1);
        end
        if ((state_q != StIdle) && (state_q != StArb)) begin
            GRANT[gidx_q] = 1'b1;
        end

        if (timeout) begin
            REQ_FAIL[gidx_q] = 1'b1;
            rr_d             = next_rr;
            state_d          = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|REQ_VALID) begin
                        state_d = StArb;
                    end
                end
                StArb: begin
                    if (arb_found) begin
                        GRANT[arb_idx]     = 1'b1;
                        REQ_READY[arb_idx] = 1'b1;
                        gidx_d             = arb_idx;
                        addr_d             = req_addr[arb_idx];
                        data_d             = req_data[arb_idx];
                        pend_d             = REQ_PEND[arb_idx];
                        multi_d            = REQ_PEND[arb_idx];
                        retry_d            = '0;
                        retrying_d         = 1'b0;
                        wd_d               = '0;
                        state_d            = StSend;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StSend: begin
                    if (TX_ACK) begin
                        state_d = StAckLow;
                    end
                end
                StAckLow: begin
                    if (!TX_ACK) begin
                        state_d = pend_q ? StNext : StResult;
                    end
                end
                StNext: begin
                    if (REQ_VALID[gidx_q]) begin
                        REQ_READY[gidx_q] = 1'b1;
                        data_d            = req_data[gidx_q];
                        pend_d            = REQ_PEND[gidx_q];
                        state_d           = StSend;
                    end
                end
                StResult: begin
                    if (TX_SUCC) begin
                        REQ_DONE[gidx_q] = 1'b1;
                        state_d          = StResp;
                    end else if (TX_FAIL) begin
                        if (!multi_q && (retry_q < 3'(MAX_RETRY))) begin
                            retry_d    = retry_q + 3'd1;
                            retrying_d = 1'b1;
                            wd_d       = '0;
                        end else begin
                            REQ_FAIL[gidx_q] = 1'b1;
                        end
                        state_d = StResp;
                    end
                end
                StResp: begin
                    if (!TX_SUCC && !TX_FAIL) begin
                        if (retrying_q) begin
                            retrying_d = 1'b0;
                            state_d    = StSend;
                        end else begin
                            rr_d    = next_rr;
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= StIdle;
            gidx_q     <= '0;
            rr_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            pend_q     <= 1'b0;
            multi_q    <= 1'b0;
            retrying_q <= 1'b0;
            retry_q    <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            gidx_q     <= gidx_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
            multi_q    <= multi_d;
            retrying_q <= retrying_d;
            retry_q    <= retry_d;
            wd_q       <= wd_d;
        end
    end

    assign TX_ADDR     = addr_q;
    assign TX_DATA     = data_q;
    assign TX_PEND     = pend_q;
    assign TX_REQ      = (state_q == StSend);
    assign TX_RESP_ACK = (state_q == StResp);
    assign BUSY        = (state_q != StIdle);

endmodule
